uart_tx: RTL and testbench

// - Memory-mapped UART transmitter. It sits on the simple-system bus as a device, in the same

---
 rtl/uart_tx_pkg.sv | 30 +++
 rtl/uart_tx_fifo.sv | 55 +++++
 rtl/uart_tx.sv | 261 ++++++++++++++++++++++++++
 tb/tb_uart_tx.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the uart_tx transmitter: register offsets, FSM states,
// register field positions and the bit-length helper.
package uart_tx_pkg;

  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;
  localparam logic [3:0] OFF_IRQ    = 4'hC;

  localparam int unsigned STATUS_FULL_BIT  = 0;
  localparam int unsigned STATUS_EMPTY_BIT = 1;
  localparam int unsigned STATUS_BUSY_BIT  = 2;
  localparam int unsigned STATUS_LEVEL_LSB = 8;

  localparam int unsigned CTRL_DIV_LSB = 0;
  localparam int unsigned CTRL_IE_BIT  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_e;

  // A divider of zero would make a zero-length bit, so it is treated as one cycle.
  function automatic logic [15:0] bit_len_of(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte-wide synchronous TX FIFO with show-ahead read data; pushes into a full
// FIFO and pops from an empty FIFO are ignored.
module uart_tx_fifo #(
  parameter int unsigned Depth = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [7:0]             i_wdata,
  output logic [7:0]             o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(Depth):0] o_level
);

  localparam int unsigned PtrW   = $clog2(Depth);
  localparam int unsigned LevelW = PtrW + 1;

  logic [7:0]        r_mem [Depth];
  logic [PtrW-1:0]   r_wr_ptr;
  logic [PtrW-1:0]   r_rd_ptr;
  logic [LevelW-1:0] r_level;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_full    = (r_level == LevelW'(Depth));
  assign o_empty   = (r_level == {LevelW{1'b0}});
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign o_level   = r_level;

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= {PtrW{1'b0}};
      r_rd_ptr <= {PtrW{1'b0}};
      r_level  <= {LevelW{1'b0}};
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LevelW'(1);
        2'b01:   r_level <= r_level - LevelW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus register file, TX FIFO, frame FSM
// with per-frame bit length, and a maskable transmit-done interrupt.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32,
  parameter int unsigned FifoDepth    = 8,
  parameter logic [15:0] DefaultDiv   = 16'd16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [3:0]              be_i,
  input  logic [AddressWidth-1:0] addr_i,
  input  logic [DataWidth-1:0]    wdata_i,
  output logic                    rvalid_o,
  output logic [DataWidth-1:0]    rdata_o,
  output logic                    err_o,
  output logic                    tx_o,
  output logic                    irq_o
);

  localparam int unsigned LevelW = $clog2(FifoDepth) + 1;

  logic                 r_rvalid;
  logic [DataWidth-1:0] r_rdata;
  logic                 r_err;
  logic [15:0]          r_div;
  logic                 r_ie;
  logic                 r_done;
  logic                 r_irq;
  logic                 r_tx;
  uart_tx_state_e       r_state;
  logic [7:0]           r_shift;
  logic [15:0]          r_bit_len;
  logic [15:0]          r_cnt;
  logic [2:0]           r_bit_idx;

  logic [3:0]           w_off;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_err;
  logic [DataWidth-1:0] w_rdata;
  logic [DataWidth-1:0] w_status;
  logic [DataWidth-1:0] w_ctrl;
  logic [15:0]          w_div_next;
  logic                 w_ie_next;
  logic                 w_done_set;
  logic                 w_done_clr;
  logic [7:0]           w_fifo_rdata;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [LevelW-1:0]    w_fifo_level;
  uart_tx_state_e       w_state_next;
  logic [7:0]           w_shift_next;
  logic [15:0]          w_bit_len_next;
  logic [15:0]          w_cnt_next;
  logic [2:0]           w_bit_idx_next;
  logic                 w_tx_next;
  logic                 w_unused;

  assign w_off    = {addr_i[3:2], 2'b00};
  assign w_unused = ^{addr_i[AddressWidth-1:4], addr_i[1:0], be_i[3], wdata_i[DataWidth-1:17]};

  uart_tx_fifo #(
    .Depth (FifoDepth)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (wdata_i[7:0]),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (w_fifo_level)
  );

  always_comb begin
    w_status                              = {DataWidth{1'b0}};
    w_status[STATUS_FULL_BIT]             = w_fifo_full;
    w_status[STATUS_EMPTY_BIT]            = w_fifo_empty;
    w_status[STATUS_BUSY_BIT]             = (r_state != IDLE);
    w_status[STATUS_LEVEL_LSB +: 8]       = 8'(w_fifo_level);
    w_ctrl                                = {DataWidth{1'b0}};
    w_ctrl[CTRL_DIV_LSB +: 16]            = r_div;
    w_ctrl[CTRL_IE_BIT]                   = r_ie;
  end

  // Register decode; full is judged on the pre-pop level, and a refused push is dropped.
  always_comb begin
    w_push      = 1'b0;
    w_err       = 1'b0;
    w_rdata     = {DataWidth{1'b0}};
    w_div_next  = r_div;
    w_ie_next   = r_ie;
    w_done_clr  = 1'b0;
    if (req_i && we_i) begin
      case (w_off)
        OFF_TXDATA: begin
          if (be_i[0]) begin
            w_push = ~w_fifo_full;
            w_err  = w_fifo_full;
          end else begin
            w_push = 1'b0;
          end
        end
        OFF_STATUS: w_err = 1'b1;
        OFF_CTRL: begin
          if (be_i[0]) w_div_next[7:0] = wdata_i[CTRL_DIV_LSB +: 8];
          else         w_div_next[7:0] = r_div[7:0];
          if (be_i[1]) w_div_next[15:8] = wdata_i[CTRL_DIV_LSB + 8 +: 8];
          else         w_div_next[15:8] = r_div[15:8];
          if (be_i[2]) w_ie_next = wdata_i[CTRL_IE_BIT];
          else         w_ie_next = r_ie;
        end
        OFF_IRQ: begin
          if (be_i[0] && wdata_i[0]) w_done_clr = 1'b1;
          else                       w_done_clr = 1'b0;
        end
        default: w_err = 1'b0;
      endcase
    end else if (req_i) begin
      case (w_off)
        OFF_STATUS: w_rdata = w_status;
        OFF_CTRL:   w_rdata = w_ctrl;
        OFF_IRQ:    w_rdata = {{(DataWidth-1){1'b0}}, r_done};
        default:    w_rdata = {DataWidth{1'b0}};
      endcase
    end else begin
      w_push = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_rdata  <= {DataWidth{1'b0}};
      r_err    <= 1'b0;
      r_div    <= DefaultDiv;
      r_ie     <= 1'b0;
    end else begin
      r_rvalid <= req_i;
      r_rdata  <= w_rdata;
      r_err    <= w_err;
      r_div    <= w_div_next;
      r_ie     <= w_ie_next;
    end
  end

  // Frame sequencer; STOP reloads directly from the FIFO so back-to-back frames have no gap.
  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_len_next = r_bit_len;
    w_cnt_next     = r_cnt;
    w_bit_idx_next = r_bit_idx;
    w_pop          = 1'b0;
    w_done_set     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_fifo_empty) begin
          w_pop          = 1'b1;
          w_shift_next   = w_fifo_rdata;
          w_bit_len_next = bit_len_of(r_div);
          w_cnt_next     = bit_len_of(r_div) - 16'd1;
          w_state_next   = START;
        end else begin
          w_state_next   = IDLE;
        end
      end
      START: begin
        if (r_cnt == 16'd0) begin
          w_state_next   = DATA;
          w_cnt_next     = r_bit_len - 16'd1;
          w_bit_idx_next = 3'd0;
        end else begin
          w_cnt_next     = r_cnt - 16'd1;
        end
      end
      DATA: begin
        if (r_cnt == 16'd0) begin
          w_cnt_next = r_bit_len - 16'd1;
          if (r_bit_idx == 3'd7) begin
            w_state_next   = STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
            w_shift_next   = {1'b0, r_shift[7:1]};
          end
        end else begin
          w_cnt_next = r_cnt - 16'd1;
        end
      end
      STOP: begin
        if (r_cnt == 16'd0) begin
          if (!w_fifo_empty) begin
            w_pop          = 1'b1;
            w_shift_next   = w_fifo_rdata;
            w_bit_len_next = bit_len_of(r_div);
            w_cnt_next     = bit_len_of(r_div) - 16'd1;
            w_state_next   = START;
          end else begin
            w_state_next   = IDLE;
            w_done_set     = 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt - 16'd1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_shift   <= 8'd0;
      r_bit_len <= 16'd1;
      r_cnt     <= 16'd0;
      r_bit_idx <= 3'd0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_len <= w_bit_len_next;
      r_cnt     <= w_cnt_next;
      r_bit_idx <= w_bit_idx_next;
      r_tx      <= w_tx_next;
    end
  end

  // A set in the same cycle as a software clear takes priority.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_done <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      if (w_done_set)      r_done <= 1'b1;
      else if (w_done_clr) r_done <= 1'b0;
      else                 r_done <= r_done;
      r_irq <= r_ie & r_done;
    end
  end

  assign rvalid_o = r_rvalid;
  assign rdata_o  = r_rdata;
  assign err_o    = r_err;
  assign tx_o     = r_tx;
  assign irq_o    = r_irq;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: bus responses are scoreboarded, serial frames
// are compared cycle by cycle against bit queues filled when bytes are written.
module tb_uart_tx;
  import uart_tx_pkg::*;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [3:0]  be_i = 4'h0;
  logic [31:0] addr_i = 32'h0;
  logic [31:0] wdata_i = 32'h0;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        tx_o;
  logic        irq_o;

  int    n_checks = 0;
  int    n_fails  = 0;
  resp_t resp_q[$];
  logic  tx_q[$];
  logic  req_d = 1'b0;
  resp_t mon_r;

  uart_tx dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (req_i),
    .we_i     (we_i),
    .be_i     (be_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .err_o    (err_o),
    .tx_o     (tx_o),
    .irq_o    (irq_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) req_d <= req_i;

  // Response scoreboard: rvalid one cycle after each request, data/err as queued.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      n_checks++;
      if (rvalid_o !== req_d)
        $display("FAIL rvalid_timing: got %b expected %b at %0t", rvalid_o, req_d, $time);
      if (rvalid_o === 1'b1) begin
        n_checks++;
        if (resp_q.size() == 0) begin
          n_fails++;
          $display("FAIL resp_unexpected: got rvalid with no pending request at %0t", $time);
        end else begin
          mon_r = resp_q.pop_front();
          if (rdata_o !== mon_r.rdata || err_o !== mon_r.err) begin
            n_fails++;
            $display("FAIL resp_data: got rdata=%h err=%b expected rdata=%h err=%b at %0t",
                     rdata_o, err_o, mon_r.rdata, mon_r.err, $time);
          end
        end
      end
      if (rvalid_o !== req_d) n_fails++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic bus_drive(input logic we, input logic [3:0] be, input logic [3:0] off,
                           input logic [31:0] wdata, input logic exp_err,
                           input logic [31:0] exp_rdata);
    logic [31:0] a;
    a      = $urandom;
    a[3:2] = off[3:2];
    req_i = 1'b1; we_i = we; be_i = be; addr_i = a; wdata_i = wdata;
    resp_q.push_back('{err: exp_err, rdata: exp_rdata});
    @(negedge clk_i);
    req_i = 1'b0; we_i = 1'b0; be_i = 4'h0; wdata_i = 32'h0;
  endtask

  task automatic push_frame(input logic [7:0] b);
    tx_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) tx_q.push_back(b[i]);
    tx_q.push_back(1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    n_checks++;
    if (tx_o !== 1'b1 || rvalid_o !== 1'b0 || rdata_o !== 32'h0 || err_o !== 1'b0 || irq_o !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_outputs: got tx=%b rvalid=%b rdata=%h err=%b irq=%b expected 1 0 0 0 0",
               tx_o, rvalid_o, rdata_o, err_o, irq_o);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
    bus_drive(1'b0, 4'hF, OFF_STATUS, 32'h0, 1'b0, 32'h0000_0002);
    bus_drive(1'b0, 4'hF, OFF_CTRL,   32'h0, 1'b0, 32'h0000_0010);
    bus_drive(1'b0, 4'hF, OFF_IRQ,    32'h0, 1'b0, 32'h0000_0000);
    @(negedge clk_i);
  endtask

  task automatic test_frame();
    logic exp_bit;
    exp_bit = 1'b1;
    bus_drive(1'b1, 4'b0011, OFF_CTRL, 32'd4, 1'b0, 32'h0);
    push_frame(8'h55);
    bus_drive(1'b1, 4'b0001, OFF_TXDATA, 32'h0000_0055, 1'b0, 32'h0);
    n_checks++;
    if (tx_o !== 1'b1) begin
      n_fails++;
      $display("FAIL frame_latency_early: got tx=%b expected 1", tx_o);
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      if (c % 4 == 0) exp_bit = tx_q.pop_front();
      n_checks++;
      if (tx_o !== exp_bit) begin
        n_fails++;
        $display("FAIL frame_55 cycle %0d: got tx=%b expected %b", c, tx_o, exp_bit);
      end
    end
    @(negedge clk_i);
    bus_drive(1'b0, 4'hF, OFF_STATUS, 32'h0, 1'b0, 32'h0000_0002);
    @(negedge clk_i);
  endtask

  task automatic test_fill();
    bus_drive(1'b1, 4'b0011, OFF_CTRL, 32'h0000_FFFF, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++)
      bus_drive(1'b1, 4'b0001, OFF_TXDATA, 32'h30 + 32'(i), (i == 9) ? 1'b1 : 1'b0, 32'h0);
    bus_drive(1'b0, 4'hF, OFF_STATUS, 32'h0, 1'b0, 32'h0000_0805);
    do_reset();
  endtask

  task automatic test_irq();
    logic exp_bit;
    exp_bit = 1'b1;
    bus_drive(1'b1, 4'b0111, OFF_CTRL, 32'h0001_0002, 1'b0, 32'h0);
    push_frame(8'hA3);
    push_frame(8'h3C);
    bus_drive(1'b1, 4'b0001, OFF_TXDATA, 32'h0000_00A3, 1'b0, 32'h0);
    bus_drive(1'b1, 4'b0001, OFF_TXDATA, 32'h0000_003C, 1'b0, 32'h0);
    for (int c = 0; c < 40; c++) begin
      if (c % 2 == 0) exp_bit = tx_q.pop_front();
      n_checks++;
      if (tx_o !== exp_bit) begin
        n_fails++;
        $display("FAIL frames_contiguous cycle %0d: got tx=%b expected %b", c, tx_o, exp_bit);
      end
      n_checks++;
      if (irq_o !== 1'b0) begin
        n_fails++;
        $display("FAIL irq_early cycle %0d: got irq=%b expected 0", c, irq_o);
      end
      @(negedge clk_i);
    end
    for (int k = 0; k < 8; k++) begin
      if (irq_o === 1'b1) break;
      @(negedge clk_i);
    end
    n_checks++;
    if (irq_o !== 1'b1) begin
      n_fails++;
      $display("FAIL irq_rise: got irq=%b expected 1 within 8 cycles", irq_o);
    end
    bus_drive(1'b1, 4'b0001, OFF_IRQ, 32'h0000_0001, 1'b0, 32'h0);
    @(negedge clk_i);
    n_checks++;
    if (irq_o !== 1'b0) begin
      n_fails++;
      $display("FAIL irq_clear: got irq=%b expected 0", irq_o);
    end
    bus_drive(1'b0, 4'hF, OFF_IRQ, 32'h0, 1'b0, 32'h0);
    @(negedge clk_i);
  endtask

  task automatic test_bus();
    bus_drive(1'b0, 4'hF, OFF_STATUS, 32'h0, 1'b0, 32'h0000_0002);
    bus_drive(1'b1, 4'hF, OFF_STATUS, 32'hFFFF_FFFF, 1'b1, 32'h0);
    n_checks++;
    if (rvalid_o !== 1'b1 || err_o !== 1'b1) begin
      n_fails++;
      $display("FAIL status_write_err: got rvalid=%b err=%b expected 1 1", rvalid_o, err_o);
    end
    bus_drive(1'b0, 4'hF, OFF_TXDATA, 32'h0, 1'b0, 32'h0);
    bus_drive(1'b0, 4'hF, OFF_CTRL, 32'h0, 1'b0, 32'h0001_0002);
    @(negedge clk_i);
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    logic       exp_bit;
    b = 8'hC5;
    exp_bit = 1'b1;
    bus_drive(1'b1, 4'b0011, OFF_CTRL, 32'd4, 1'b0, 32'h0);
    bus_drive(1'b1, 4'b0001, OFF_TXDATA, {24'h0, b}, 1'b0, 32'h0);
    repeat (18) @(negedge clk_i);
    n_checks++;
    if (tx_o !== b[3]) begin
      n_fails++;
      $display("FAIL data_bit3_before_reset: got tx=%b expected %b", tx_o, b[3]);
    end
    #2 rst_ni = 1'b0;
    #1;
    n_checks++;
    if (tx_o !== 1'b1) begin
      n_fails++;
      $display("FAIL reset_async_tx: got tx=%b expected 1", tx_o);
    end
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    bus_drive(1'b0, 4'hF, OFF_STATUS, 32'h0, 1'b0, 32'h0000_0002);
    bus_drive(1'b0, 4'hF, OFF_CTRL,   32'h0, 1'b0, 32'h0000_0010);
    push_frame(8'h96);
    bus_drive(1'b1, 4'b0001, OFF_TXDATA, 32'h0000_0096, 1'b0, 32'h0);
    for (int c = 0; c < 160; c++) begin
      @(negedge clk_i);
      if (c % 16 == 0) exp_bit = tx_q.pop_front();
      n_checks++;
      if (tx_o !== exp_bit) begin
        n_fails++;
        $display("FAIL frame_after_reset cycle %0d: got tx=%b expected %b", c, tx_o, exp_bit);
      end
    end
    @(negedge clk_i);
  endtask

  task automatic test_ctrl_be();
    logic        exp_bit;
    logic [31:0] a;
    exp_bit = 1'b1;
    a = 32'h0;
    a[3:0] = OFF_CTRL;
    bus_drive(1'b1, 4'b0100, OFF_CTRL, 32'h0001_FFFF, 1'b0, 32'h0);
    bus_drive(1'b0, 4'hF, OFF_CTRL, 32'h0, 1'b0, 32'h0001_0010);
    bus_drive(1'b1, 4'b0011, OFF_CTRL, 32'd3, 1'b0, 32'h0);
    push_frame(8'h5A);
    bus_drive(1'b1, 4'b0001, OFF_TXDATA, 32'h0000_005A, 1'b0, 32'h0);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_i);
      if (c == 11) begin
        req_i = 1'b0; we_i = 1'b0; be_i = 4'h0; wdata_i = 32'h0;
      end
      if (c % 3 == 0) exp_bit = tx_q.pop_front();
      n_checks++;
      if (tx_o !== exp_bit) begin
        n_fails++;
        $display("FAIL frame_div_mid cycle %0d: got tx=%b expected %b", c, tx_o, exp_bit);
      end
      if (c == 10) begin
        req_i = 1'b1; we_i = 1'b1; be_i = 4'b0001; addr_i = a; wdata_i = 32'd6;
        resp_q.push_back('{err: 1'b0, rdata: 32'h0});
      end
    end
    @(negedge clk_i);
    push_frame(8'hE1);
    bus_drive(1'b1, 4'b0001, OFF_TXDATA, 32'h0000_00E1, 1'b0, 32'h0);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk_i);
      if (c % 6 == 0) exp_bit = tx_q.pop_front();
      n_checks++;
      if (tx_o !== exp_bit) begin
        n_fails++;
        $display("FAIL frame_div_next cycle %0d: got tx=%b expected %b", c, tx_o, exp_bit);
      end
    end
    @(negedge clk_i);
  endtask

  initial begin
    test_reset();
    test_frame();
    test_fill();
    test_irq();
    test_bus();
    test_reset_mid();
    test_ctrl_be();
    repeat (2) @(negedge clk_i);
    n_checks++;
    if (resp_q.size() != 0 || tx_q.size() != 0) begin
      n_fails++;
      $display("FAIL queues_drained: got resp=%0d tx=%0d expected 0 0", resp_q.size(), tx_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
